// File: rtl/out_port.sv
// Router output port: wormhole-locked round-robin arbiter, per-VC credit tracking, registered link flit.
// Optional macro OUT_PORT_CREDIT_CHECK_EN adds a sticky credit_err output.

`ifndef FLIT_SIZE
`define FLIT_SIZE 16
`endif
`ifndef FLIT_TYPE
`define FLIT_TYPE 15:14
`endif
`ifndef FLIT_VC
`define FLIT_VC 13:11
`endif

module out_port #(
  parameter int IN_NUM    = 4,
  parameter int VC_NUM    = 4,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [IN_NUM*`FLIT_SIZE-1:0] flit_in,
  input  logic [IN_NUM-1:0]            req,
  output logic [IN_NUM-1:0]            grant,
  input  logic [VC_NUM-1:0]            credit_in,
  output logic [`FLIT_SIZE-1:0]        flit_out,
  output logic                         valid_out,
  output logic [VC_NUM-1:0]            credit_avail
`ifdef OUT_PORT_CREDIT_CHECK_EN
  , output logic                       credit_err
`endif
);

  localparam int PW = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int FS = `FLIT_SIZE;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q;
  logic [PW-1:0]    rrPtr_q, owner_q;
  logic [2:0]       lockVc_q;
  logic [CNT_W-1:0] cnt_q [VC_NUM];
  logic [CNT_W-1:0] cnt_d [VC_NUM];
  logic [FS-1:0]    flitOut_q;
  logic             validOut_q;

  logic [FS-1:0]     portFlit [IN_NUM];
  logic [IN_NUM-1:0] portReq, eligible;
  logic [1:0]        pType;
  logic [2:0]        pVc;
  logic              pCredit;

  // Port 0 occupies the MSBs of flit_in, req and grant.
  always_comb begin
    pType    = '0;
    pVc      = '0;
    pCredit  = 1'b0;
    eligible = '0;
    portReq  = '0;
    for (int p = 0; p < IN_NUM; p++) begin
      portFlit[p] = flit_in[(IN_NUM-1-p)*FS +: FS];
      portReq[p]  = req[IN_NUM-1-p];
      pType       = portFlit[p][`FLIT_TYPE];
      pVc         = portFlit[p][`FLIT_VC];
      pCredit     = 1'b0;
      for (int v = 0; v < VC_NUM; v++)
        if (int'(pVc) == v && cnt_q[v] != '0) pCredit = 1'b1;
      if (!reset && portReq[p] && pCredit) begin
        if (state_q == IDLE)
          eligible[p] = pType[0];
        else
          eligible[p] = (int'(owner_q) == p) && !pType[0] && (pVc == lockVc_q);
      end
    end
  end

  logic          gntValid;
  logic [PW-1:0] gntIdx, rrNext;
  logic [FS-1:0] gntFlit;
  logic [1:0]    gntType;
  logic [2:0]    gntVc;

  // Two passes give the rotating priority: rr_ptr..IN_NUM-1 first, then 0..rr_ptr-1.
  always_comb begin
    gntValid = 1'b0;
    gntIdx   = '0;
    gntFlit  = '0;
    grant    = '0;
    for (int p = 0; p < IN_NUM; p++)
      if (!gntValid && eligible[p] && int'(rrPtr_q) <= p) begin
        gntValid = 1'b1;
        gntIdx   = PW'(p);
        gntFlit  = portFlit[p];
        grant[IN_NUM-1-p] = 1'b1;
      end
    for (int p = 0; p < IN_NUM; p++)
      if (!gntValid && eligible[p] && p < int'(rrPtr_q)) begin
        gntValid = 1'b1;
        gntIdx   = PW'(p);
        gntFlit  = portFlit[p];
        grant[IN_NUM-1-p] = 1'b1;
      end
    gntType = gntFlit[`FLIT_TYPE];
    gntVc   = gntFlit[`FLIT_VC];
    rrNext  = (gntIdx == PW'(IN_NUM-1)) ? '0 : gntIdx + PW'(1);
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      cnt_d[v]        = cnt_q[v];
      credit_avail[v] = (cnt_q[v] != '0);
      if (credit_in[v] && !(gntValid && int'(gntVc) == v)) begin
        if (cnt_q[v] != FULL) cnt_d[v] = cnt_q[v] + CNT_W'(1);
      end else if (!credit_in[v] && gntValid && int'(gntVc) == v) begin
        cnt_d[v] = cnt_q[v] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      owner_q    <= '0;
      lockVc_q   <= '0;
      flitOut_q  <= '0;
      validOut_q <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) cnt_q[v] <= FULL;
    end else begin
      for (int v = 0; v < VC_NUM; v++) cnt_q[v] <= cnt_d[v];
      validOut_q <= gntValid;
      if (gntValid) flitOut_q <= gntFlit;
      case (state_q)
        IDLE: if (gntValid) begin
          rrPtr_q <= rrNext;
          if (gntType == 2'b01) begin
            state_q  <= LOCKED;
            owner_q  <= gntIdx;
            lockVc_q <= gntVc;
          end
        end
        LOCKED: if (gntValid && gntType == 2'b10) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign flit_out  = flitOut_q;
  assign valid_out = validOut_q;

`ifdef OUT_PORT_CREDIT_CHECK_EN
  logic creditErr_q, errSet;
  logic [1:0] oType;

  always_comb begin
    errSet = 1'b0;
    oType  = '0;
    for (int v = 0; v < VC_NUM; v++)
      if (credit_in[v] && cnt_q[v] == FULL && !(gntValid && int'(gntVc) == v)) errSet = 1'b1;
    for (int p = 0; p < IN_NUM; p++) begin
      oType = portFlit[p][`FLIT_TYPE];
      if (state_q == LOCKED && int'(owner_q) == p && portReq[p] && oType[0]) errSet = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       creditErr_q <= 1'b0;
    else if (errSet) creditErr_q <= 1'b1;
  end

  assign credit_err = creditErr_q;
`else
  // Without the checker, surplus credits simply saturate and protocol violations are only held off.
`endif

endmodule

// File: doc/out_port.md
Name: out_port

Overview:
- Output stage of a router port; sits directly downstream of the input ports.
- Arbitrates among IN_NUM input-port requesters with wormhole locking: a packet holds the output from its head flit to its tail flit.
- Tracks per-VC credits for the downstream router's input buffers and drives one registered flit per cycle onto the link.
- Exports per-VC credit availability back to the input ports, which use it as credit_next_router.

Parameters:
- IN_NUM, 4, number of requesting input ports
- VC_NUM, 4, number of virtual channels; the `FLIT_VC field is 3 bits wide
- BUF_DEPTH, 4, downstream per-VC buffer depth; this is the initial credit count (1..7)
- CNT_W, 3, credit counter width; must satisfy 2^CNT_W > BUF_DEPTH

Ports:
- clock  in  1  system clock, all state on the rising edge
- reset  in  1  synchronous, active-high
- flit_in  in  IN_NUM*`FLIT_SIZE  concatenated candidate flits; port 0 occupies the MSBs
- req  in  IN_NUM  port p presents a valid flit this cycle
- grant  out  IN_NUM  one-hot, combinational; the flit of port p is consumed this cycle
- credit_in  in  VC_NUM  downstream credit return; one cycle high = one slot freed for that VC
- flit_out  out  `FLIT_SIZE  registered link flit
- valid_out  out  1  flit_out is valid this cycle
- credit_avail  out  VC_NUM  bit v = (cnt[v] != 0)

Behaviour:
- Flit fields come from constants.v:
  - `FLIT_VC selects the VC.
  - `FLIT_TYPE is 2 bits: 00 body, 01 head, 10 tail, 11 single (head+tail).
- Per-VC credit counters cnt[v]:
  - Reset value BUF_DEPTH.
  - Decrement on a grant whose flit VC is v.
  - Increment on credit_in[v].
  - Both in the same cycle: unchanged.
  - Increment while at BUF_DEPTH: saturate at BUF_DEPTH.
  - Decrement never occurs at 0, because a grant requires cnt > 0.
- Eligibility for port p: req[p] && cnt[vc(p)] != 0, plus the FSM condition below.
- FSM, two states:
  - IDLE: only flits with type head or single are eligible. Round-robin search starts at rr_ptr (wraps from IN_NUM-1 to 0).
    - Head granted from p: go to LOCKED with owner=p, lock_vc=vc(p).
    - Single granted from p: stay in IDLE.
    - In both cases rr_ptr <= (p+1) mod IN_NUM.
  - LOCKED: only the owner is eligible. Its flit must be body or tail, and its VC must equal lock_vc.
    - Tail granted: return to IDLE.
    - Body granted: stay in LOCKED.
    - A head/single from the owner, or a flit with a mismatched VC, is not granted; state is held.
- grant is combinational from the current state, req, flit_in and cnt. At most one bit is high.
- Output register, latency 1 cycle from grant:
  - On grant: flit_out <= granted flit, valid_out <= 1.
  - Otherwise: valid_out <= 0 and flit_out holds its previous value.
- credit_avail is combinational from cnt. It reflects the registered counters and does not include same-cycle credit_in.
- Reset values: state IDLE, rr_ptr 0, owner 0, lock_vc 0, cnt[*] BUF_DEPTH, flit_out 0, valid_out 0, grant 0 while reset is high.
- Reset asserted mid-packet aborts the lock immediately: the next cycle is IDLE with full credits. No flit is emitted in the cycle after reset.
- Throughput: one flit per cycle when credits are available. A tail in cycle n allows a new head in cycle n+1.

Optional Feature:
- Macro: OUT_PORT_CREDIT_CHECK_EN.
- Defined:
  - Adds output credit_err (1 bit, sticky, cleared only by reset).
  - credit_err sets on credit_in[v] while cnt[v]==BUF_DEPTH with no same-cycle decrement (overflow).
  - credit_err also sets in LOCKED when the owner presents a head/single flit (protocol violation).
- Not defined: the port does not exist; saturation and hold behaviour are unchanged.

Test Plan:
- Reset, then idle for 3 cycles -> cnt all 4, credit_avail=4'b1111, valid_out=0, grant=0.
- Ports 0 and 2 present single flits on VC1 in the same cycle with rr_ptr=0 -> grant=4'b1000; next cycle grant=4'b0010; valid_out high for 2 cycles; cnt[1]=2.
- Port 1 sends head, body, body, tail on VC2 while port 3 holds a head request -> port 3 is blocked until the cycle after the tail is granted, then granted; output order is port1 ×4, then port3.
- 4 single flits on VC0 with no credit_in -> cnt[0]=0, credit_avail[0]=0, a 5th request gets no grant; one credit_in[0] pulse -> grant in the following cycle.
- Grant on VC3 and credit_in[3] in the same cycle at cnt[3]=2 -> cnt[3] stays 2; credit_in[3] at cnt[3]=4 -> stays 4 (credit_err=1 with OUT_PORT_CREDIT_CHECK_EN).
- Reset asserted in LOCKED after a head and one body -> next cycle state IDLE, cnt all 4, valid_out=0; a pending body from the former owner is not granted.
